// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that stall decode on RAW hazards
// clk, reset                    clock and async active-high reset
// issue_valid/ra1/ra2/we/wa     decode-stage instruction; issue_ready = may issue this cycle
// wb_valid, wb_wa               writeback retiring a write to wb_wa
// busy_mask, idle               registers with pending writes; none pending
// underflow_err                 sticky: writeback seen with nothing pending
module reg_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int N_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [4:0]        issue_ra1,
  input  logic [4:0]        issue_ra2,
  input  logic              issue_we,
  input  logic [4:0]        issue_wa,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_wa,
  output logic [N_REGS-1:0] busy_mask,
  output logic              idle,
  output logic              underflow_err
);
  logic [N_REGS-1:0] at_max;
  logic [N_REGS-2:0] uf;
  logic              accept;
  assign busy_mask[N_REGS-1] = 1'b0;
  assign at_max[N_REGS-1]    = 1'b0;
  assign issue_ready = !(busy_mask[issue_ra1] || busy_mask[issue_ra2] || (issue_we && at_max[issue_wa]));
  assign accept      = issue_valid && issue_ready;
  assign idle        = ~|busy_mask;
  for (genvar r = 0; r < N_REGS - 1; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    logic             inc, dec;
    assign inc          = accept && issue_we && issue_wa == 5'(r);
    assign dec          = wb_valid && wb_wa == 5'(r) && cnt != '0;
    assign uf[r]        = wb_valid && wb_wa == 5'(r) && cnt == '0;
    assign busy_mask[r] = |cnt;
    assign at_max[r]    = &cnt;
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (inc && !dec) cnt <= cnt + 1'b1;
      else if (dec && !inc) cnt <= cnt - 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) underflow_err <= 1'b0;
    else if (|uf) underflow_err <= 1'b1;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  logic        clk = 0;
  logic        reset = 1;
  logic        issue_valid = 0, issue_we = 0, wb_valid = 0;
  logic [4:0]  issue_ra1 = 0, issue_ra2 = 0, issue_wa = 0, wb_wa = 0;
  logic        issue_ready, idle, underflow_err;
  logic [31:0] busy_mask;
  int          n_chk = 0, n_fail = 0;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ra1(issue_ra1), .issue_ra2(issue_ra2),
    .issue_we(issue_we), .issue_wa(issue_wa), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_wa(wb_wa),
    .busy_mask(busy_mask), .idle(idle), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_we = 0; issue_wa = 0; issue_ra1 = 0; issue_ra2 = 0;
    wb_valid = 0; wb_wa = 0;
    #1;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
    issue_valid = 1; issue_we = 1; issue_wa = wa; issue_ra1 = ra1; issue_ra2 = ra2;
    #1;
  endtask

  task automatic wb(input logic [4:0] wa);
    wb_valid = 1; wb_wa = wa;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'($urandom); issue_we = 1'($urandom); issue_wa = 5'($urandom);
      wb_valid = 1'($urandom); wb_wa = 5'($urandom);
      issue_ra1 = 5'($urandom); issue_ra2 = 5'($urandom);
      tick();
    end
    issue_ra1 = 5; issue_ra2 = 5; issue_we = 0;
    #1;
    n_chk++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want %h", busy_mask, 32'h0); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
    n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b want 0", underflow_err); end
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    quiet();
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_raw();
    issue(3, 0, 0);
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got %b want 1", issue_ready); end
    tick();
    quiet();
    issue_ra1 = 3;
    #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %b want 0", issue_ready); end
    n_chk++; if (busy_mask !== 32'h8) begin n_fail++; $display("FAIL raw_busy got %h want %h", busy_mask, 32'h8); end
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL raw_idle got %b want 0", idle); end
    issue_ra1 = 0; issue_ra2 = 3;
    #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ra2 got %b want 0", issue_ready); end
    wb(3);
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_same_cycle got %b want 0", issue_ready); end
    tick();
    wb_valid = 0;
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_clear_ready got %b want 1", issue_ready); end
    n_chk++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL raw_clear_busy got %h want 0", busy_mask); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL raw_clear_idle got %b want 1", idle); end
    quiet();
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      issue(7, 0, 0);
      n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got %b want 1", i, issue_ready); end
      tick();
    end
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_block got %b want 0", issue_ready); end
    n_chk++; if (busy_mask !== 32'h80) begin n_fail++; $display("FAIL full_busy got %h want %h", busy_mask, 32'h80); end
    issue_valid = 0;
    #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_valid got %b want 0", issue_ready); end
    issue_valid = 1;
    tick();
    issue_valid = 0; issue_we = 0;
    wb(7);
    tick();
    quiet();
    issue(7, 0, 0);
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_wb got %b want 1", issue_ready); end
    tick();
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_refilled got %b want 0", issue_ready); end
    quiet();
    for (int i = 0; i < 3; i++) begin
      wb(7);
      tick();
    end
    quiet();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_drain_idle got %b want 1", idle); end
    n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL full_drain_uf got %b want 0", underflow_err); end
  endtask

  task automatic test_same_cycle();
    issue(9, 0, 0);
    tick();
    wb(9);
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready got %b want 1", issue_ready); end
    tick();
    quiet();
    n_chk++; if (busy_mask !== 32'h200) begin n_fail++; $display("FAIL same_busy got %h want %h", busy_mask, 32'h200); end
    n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL same_uf got %b want 0", underflow_err); end
    wb(9);
    tick();
    quiet();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL same_drain_idle got %b want 1", idle); end
  endtask

  task automatic test_xzr();
    for (int i = 0; i < 5; i++) begin
      issue(31, 31, 31);
      n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL xzr_ready%0d got %b want 1", i, issue_ready); end
      tick();
    end
    n_chk++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL xzr_busy got %h want 0", busy_mask); end
    quiet();
    wb(31);
    tick();
    quiet();
    n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL xzr_uf got %b want 0", underflow_err); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL xzr_idle got %b want 1", idle); end
  endtask

  task automatic test_underflow();
    wb(12);
    tick();
    quiet();
    n_chk++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b want 1", underflow_err); end
    n_chk++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL uf_no_wrap got %h want 0", busy_mask); end
    issue(1, 0, 0); tick();
    issue(2, 0, 0); tick();
    issue(4, 0, 0); tick();
    issue(5, 0, 0); tick();
    quiet();
    n_chk++; if (busy_mask !== 32'h36) begin n_fail++; $display("FAIL uf_busy4 got %h want %h", busy_mask, 32'h36); end
    n_chk++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", underflow_err); end
    reset = 1;
    #1;
    n_chk++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL async_busy got %h want 0", busy_mask); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL async_idle got %b want 1", idle); end
    n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL async_uf got %b want 0", underflow_err); end
    @(negedge clk);
    reset = 0;
    tick();
    issue(20, 0, 0);
    wb(20);
    tick();
    quiet();
    n_chk++; if (busy_mask !== 32'h0010_0000) begin n_fail++; $display("FAIL incwb0_busy got %h want %h", busy_mask, 32'h0010_0000); end
    n_chk++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL incwb0_uf got %b want 1", underflow_err); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_same_cycle();
    test_xzr();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
